// File: rtl/eth_phy_init_ctrl_if.sv
// MDIO master request/acknowledge bus between the PHY init sequencer and the MDIO engine.
interface eth_phy_init_ctrl_if;
    logic        mdio_req;
    logic        mdio_wr;
    logic [4:0]  mdio_phy_addr;
    logic [4:0]  mdio_reg_addr;
    logic [15:0] mdio_wdata;
    logic        mdio_ack;
    logic [15:0] mdio_rdata;

    // Sequencer side: issues requests, receives completions.
    modport master (
        output mdio_req, mdio_wr, mdio_phy_addr, mdio_reg_addr, mdio_wdata,
        input  mdio_ack, mdio_rdata
    );

    // MDIO engine side.
    modport slave (
        input  mdio_req, mdio_wr, mdio_phy_addr, mdio_reg_addr, mdio_wdata,
        output mdio_ack, mdio_rdata
    );
endinterface

// File: rtl/eth_phy_init_ctrl.sv
// SGMII PHY bring-up sequencer: hardware reset, config table writes over MDIO,
// then periodic BMSR polling for link state.
// Optional feature macro: ETH_PHY_TIMEOUT_EN (MDIO ack timeout with sticky error).
module eth_phy_init_ctrl #(
    parameter logic [4:0]  PHY_ADDR          = 5'd7,
    parameter int unsigned RESET_CYCLES      = 200000,
    parameter int unsigned POST_RESET_CYCLES = 1000000,
    parameter int unsigned NUM_CFG           = 4,
    parameter int unsigned POLL_CYCLES       = 5000000,
    parameter int unsigned TIMEOUT_CYCLES    = 100000
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_restart,
    output logic                 o_eth_reset_n,
    output logic [4:0]           o_cfg_index,
    input  logic [4:0]           i_cfg_reg,
    input  logic [15:0]          i_cfg_data,
    eth_phy_init_ctrl_if.master  mdio,
    output logic                 o_init_done,
    output logic                 o_link_up,
    output logic                 o_link_change,
    output logic                 o_error
);

    localparam int unsigned MAX_A = (RESET_CYCLES > POST_RESET_CYCLES) ? RESET_CYCLES : POST_RESET_CYCLES;
    localparam int unsigned MAX_B = (POLL_CYCLES > TIMEOUT_CYCLES) ? POLL_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W = $clog2(MAX_C) + 1;

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_CYCLES - 1);
    localparam logic [4:0]       CFG_LAST  = 5'((NUM_CFG == 0) ? 0 : NUM_CFG - 1);
    localparam logic [4:0]       BMSR_ADDR = 5'd1;

    typedef enum logic [2:0] {
        RST_HOLD, RST_WAIT, CFG_ISSUE, CFG_WAIT, POLL_ISSUE, POLL_WAIT, POLL_IDLE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic             r_pend, w_pend;
    logic             r_eth_reset_n, w_eth_reset_n;
    logic [4:0]       r_cfg_index, w_cfg_index;
    logic             r_req, w_req;
    logic             r_wr, w_wr;
    logic [4:0]       r_reg_addr, w_reg_addr;
    logic [15:0]      r_wdata, w_wdata;
    logic             r_init_done, w_init_done;
    logic             r_link_up, w_link_up;
    logic             r_link_change, w_link_change;
    logic             r_error, w_error;

    logic w_in_wait;
    logic w_ack;
    logic w_restart;
    logic w_tmo;
    logic w_abort;
    logic w_unused_rdata;

    assign w_in_wait = (r_state == CFG_WAIT) || (r_state == POLL_WAIT);
    assign w_ack     = w_in_wait & mdio.mdio_ack;
    assign w_restart = i_restart | r_pend;

`ifdef ETH_PHY_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    // Abort an outstanding request that has waited the full timeout window.
    assign w_tmo = w_in_wait & ~mdio.mdio_ack & (r_cnt == TMO_LAST);
`else
    assign w_tmo = 1'b0;
`endif

    // A restart takes effect outside a transaction, or on the ack that closes one.
    assign w_abort = (w_restart & (~w_in_wait | mdio.mdio_ack)) | w_tmo;

    assign w_unused_rdata = &{1'b0, mdio.mdio_rdata[15:3], mdio.mdio_rdata[1:0]};

    // State and datapath registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= RST_HOLD;
            r_cnt         <= '0;
            r_pend        <= 1'b0;
            r_eth_reset_n <= 1'b0;
            r_cfg_index   <= '0;
            r_req         <= 1'b0;
            r_wr          <= 1'b0;
            r_reg_addr    <= '0;
            r_wdata       <= '0;
            r_init_done   <= 1'b0;
            r_link_up     <= 1'b0;
            r_link_change <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt;
            r_pend        <= w_pend;
            r_eth_reset_n <= w_eth_reset_n;
            r_cfg_index   <= w_cfg_index;
            r_req         <= w_req;
            r_wr          <= w_wr;
            r_reg_addr    <= w_reg_addr;
            r_wdata       <= w_wdata;
            r_init_done   <= w_init_done;
            r_link_up     <= w_link_up;
            r_link_change <= w_link_change;
            r_error       <= w_error;
        end
    end

    // Next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = RST_HOLD;
        end else begin
            case (r_state)
                RST_HOLD:   if (r_cnt == RST_LAST) w_state_nxt = RST_WAIT;
                RST_WAIT:   if (r_cnt == POST_LAST) w_state_nxt = (NUM_CFG > 0) ? CFG_ISSUE : POLL_ISSUE;
                CFG_ISSUE:  w_state_nxt = CFG_WAIT;
                CFG_WAIT:   if (w_ack) w_state_nxt = (r_cfg_index == CFG_LAST) ? POLL_ISSUE : CFG_ISSUE;
                POLL_ISSUE: w_state_nxt = POLL_WAIT;
                POLL_WAIT:  if (w_ack) w_state_nxt = POLL_IDLE;
                POLL_IDLE:  if (r_cnt >= POLL_LAST) w_state_nxt = POLL_ISSUE;
                default:    w_state_nxt = RST_HOLD;
            endcase
        end
    end

    // Next values of counter, bus request fields and status outputs.
    always_comb begin
        w_cnt         = r_cnt + CNT_W'(1);
        w_pend        = r_pend | i_restart;
        w_eth_reset_n = r_eth_reset_n;
        w_cfg_index   = r_cfg_index;
        w_req         = r_req;
        w_wr          = r_wr;
        w_reg_addr    = r_reg_addr;
        w_wdata       = r_wdata;
        w_init_done   = r_init_done;
        w_link_up     = r_link_up;
        w_link_change = 1'b0;
        w_error       = r_error | w_tmo;
        if (w_abort) begin
            w_cnt         = '0;
            w_pend        = 1'b0;
            w_eth_reset_n = 1'b0;
            w_cfg_index   = '0;
            w_req         = 1'b0;
            w_init_done   = 1'b0;
            w_link_up     = 1'b0;
            w_link_change = r_link_up;
        end else begin
            case (r_state)
                RST_HOLD: begin
                    if (r_cnt == RST_LAST) begin
                        w_cnt         = '0;
                        w_eth_reset_n = 1'b1;
                    end
                end
                RST_WAIT: begin
                    if (r_cnt == POST_LAST) w_cnt = '0;
                end
                CFG_ISSUE: begin
                    w_reg_addr = i_cfg_reg;
                    w_wdata    = i_cfg_data;
                    w_wr       = 1'b1;
                    w_req      = 1'b1;
                    w_cnt      = '0;
                end
                CFG_WAIT: begin
                    if (w_ack) begin
                        w_req = 1'b0;
                        w_cnt = '0;
                        if (r_cfg_index == CFG_LAST) begin
                            w_init_done = 1'b1;
                            w_cfg_index = '0;
                        end else begin
                            w_cfg_index = r_cfg_index + 5'd1;
                        end
                    end
                end
                POLL_ISSUE: begin
                    w_wr       = 1'b0;
                    w_reg_addr = BMSR_ADDR;
                    w_req      = 1'b1;
                    w_cnt      = '0;
                end
                POLL_WAIT: begin
                    // Ack cycle counts as the first cycle of the poll interval.
                    if (w_ack) begin
                        w_req         = 1'b0;
                        w_link_up     = mdio.mdio_rdata[2];
                        w_link_change = mdio.mdio_rdata[2] ^ r_link_up;
                        w_cnt         = CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_eth_reset_n      = r_eth_reset_n;
    assign o_cfg_index        = r_cfg_index;
    assign o_init_done        = r_init_done;
    assign o_link_up          = r_link_up;
    assign o_link_change      = r_link_change;
    assign o_error            = r_error;
    assign mdio.mdio_req      = r_req;
    assign mdio.mdio_wr       = r_wr;
    assign mdio.mdio_phy_addr = PHY_ADDR;
    assign mdio.mdio_reg_addr = r_reg_addr;
    assign mdio.mdio_wdata    = r_wdata;

endmodule

// File: tb/tb_eth_phy_init_ctrl.sv
// Scoreboard bench for eth_phy_init_ctrl: reset/bring-up timing, config writes,
// BMSR polling, restart handling, optional timeout, and a NUM_CFG=0 instance.
module tb_eth_phy_init_ctrl;

    typedef struct packed {
        logic        wr;
        logic [4:0]  addr;
        logic [15:0] data;
    } txn_t;

    logic        clk;
    logic        rst;
    logic        restart;
    logic        eth_reset_n, init_done, link_up, link_change, error;
    logic [4:0]  cfg_index, cfg_reg;
    logic [15:0] cfg_data;
    logic        eth_reset_n0, init_done0, link_up0, link_change0, error0;
    logic [4:0]  cfg_index0;
    logic        mon_req_q;
    logic        done0;

    int   n_vec = 0;
    int   n_err = 0;
    txn_t q_exp[$];

    eth_phy_init_ctrl_if bus();
    eth_phy_init_ctrl_if bus0();

    eth_phy_init_ctrl #(
        .PHY_ADDR(5'd7), .RESET_CYCLES(10), .POST_RESET_CYCLES(5), .NUM_CFG(2),
        .POLL_CYCLES(20), .TIMEOUT_CYCLES(50)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_restart(restart), .o_eth_reset_n(eth_reset_n),
        .o_cfg_index(cfg_index), .i_cfg_reg(cfg_reg), .i_cfg_data(cfg_data), .mdio(bus),
        .o_init_done(init_done), .o_link_up(link_up), .o_link_change(link_change), .o_error(error)
    );

    eth_phy_init_ctrl #(
        .PHY_ADDR(5'd7), .RESET_CYCLES(10), .POST_RESET_CYCLES(5), .NUM_CFG(0),
        .POLL_CYCLES(20), .TIMEOUT_CYCLES(50)
    ) dut0 (
        .i_clock(clk), .i_reset(rst), .i_restart(1'b0), .o_eth_reset_n(eth_reset_n0),
        .o_cfg_index(cfg_index0), .i_cfg_reg(5'd0), .i_cfg_data(16'd0), .mdio(bus0),
        .o_init_done(init_done0), .o_link_up(link_up0), .o_link_change(link_change0), .o_error(error0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Config table seen by the main instance.
    always_comb begin
        case (cfg_index)
            5'd0:    begin cfg_reg = 5'd0;  cfg_data = 16'h1140; end
            5'd1:    begin cfg_reg = 5'd4;  cfg_data = 16'h01E1; end
            default: begin cfg_reg = 5'd31; cfg_data = 16'hFFFF; end
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_txn(input logic wr, input logic [4:0] addr, input logic [15:0] data);
        txn_t t;
        t.wr = wr; t.addr = addr; t.data = data;
        q_exp.push_back(t);
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!bus.mdio_req && n < 1000) begin
            tick();
            n++;
        end
        check_val("req_seen", 32'(bus.mdio_req), 32'd1);
    endtask

    task automatic wait_rst_rise(input int start, output int n);
        n = start;
        while (!eth_reset_n && n < 1000) begin
            tick();
            n++;
        end
    endtask

    // Ack the outstanding request dly edges after it rose; rmode 1 = restart mid-wait, 2 = restart with ack.
    task automatic ack_txn(input int dly, input logic [15:0] rd, input int rmode);
        for (int i = 1; i < dly; i++) begin
            if (rmode == 1 && i == 2) restart = 1'b1;
            tick();
            restart = 1'b0;
            check_val("req_hold", 32'(bus.mdio_req), 32'd1);
        end
        bus.mdio_ack   = 1'b1;
        bus.mdio_rdata = rd;
        if (rmode == 2) restart = 1'b1;
        tick();
        bus.mdio_ack   = 1'b0;
        bus.mdio_rdata = 16'h0;
        restart        = 1'b0;
        check_val("req_drop", 32'(bus.mdio_req), 32'd0);
    endtask

    // Scoreboard: every request rise is matched against the next expected transaction.
    always @(negedge clk) begin
        if (bus.mdio_req && !mon_req_q) begin
            if (q_exp.size() == 0) begin
                check_val("sb_unexpected_req", 32'd1, 32'd0);
            end else begin
                check_val("txn_wr", 32'(bus.mdio_wr), 32'(q_exp[0].wr));
                check_val("txn_addr", 32'(bus.mdio_reg_addr), 32'(q_exp[0].addr));
                if (q_exp[0].wr) check_val("txn_wdata", 32'(bus.mdio_wdata), 32'(q_exp[0].data));
                check_val("txn_phy", 32'(bus.mdio_phy_addr), 32'd7);
                void'(q_exp.pop_front());
            end
        end
        mon_req_q <= bus.mdio_req;
    end

    // NUM_CFG=0 instance: first access after reset wait is the BMSR read.
    initial begin : numcfg0
        int n;
        done0 = 1'b0;
        bus0.mdio_ack = 1'b0;
        bus0.mdio_rdata = 16'h0;
        #2;
        n = 0;
        while (!eth_reset_n0 && n < 1000) begin tick(); n++; end
        n = 0;
        while (!bus0.mdio_req && n < 1000) begin tick(); n++; end
        check_val("nc0_req_seen", 32'(bus0.mdio_req), 32'd1);
        check_val("nc0_first_gap", 32'(n), 32'd6);
        check_val("nc0_wr", 32'(bus0.mdio_wr), 32'd0);
        check_val("nc0_addr", 32'(bus0.mdio_reg_addr), 32'd1);
        repeat (2) tick();
        bus0.mdio_ack = 1'b1;
        bus0.mdio_rdata = 16'h796D;
        tick();
        bus0.mdio_ack = 1'b0;
        check_val("nc0_link_up", 32'(link_up0), 32'd1);
        check_val("nc0_init_done", 32'(init_done0), 32'd0);
        done0 = 1'b1;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        rst = 1'b1;
        restart = 1'b0;
        bus.mdio_ack = 1'b0;
        bus.mdio_rdata = 16'h0;
        mon_req_q = 1'b0;
        repeat (3) tick();
        check_val("rst_eth_reset_n", 32'(eth_reset_n), 32'd0);
        check_val("rst_req", 32'(bus.mdio_req), 32'd0);
        check_val("rst_wr", 32'(bus.mdio_wr), 32'd0);
        check_val("rst_reg_addr", 32'(bus.mdio_reg_addr), 32'd0);
        check_val("rst_wdata", 32'(bus.mdio_wdata), 32'd0);
        check_val("rst_cfg_index", 32'(cfg_index), 32'd0);
        check_val("rst_status", {28'd0, init_done, link_up, link_change, error}, 32'd0);

        // Run 1: full bring-up and four polls.
        push_txn(1'b1, 5'd0, 16'h1140);
        push_txn(1'b1, 5'd4, 16'h01E1);
        rst = 1'b0;
        wait_rst_rise(0, n);
        check_val("rst_low_cycles", 32'(n), 32'd10);
        wait_req(n);
        check_val("first_req_gap", 32'(n), 32'd6);
        ack_txn(8, 16'h0, 0);
        check_val("cfg_index_after_w0", 32'(cfg_index), 32'd1);
        check_val("init_done_after_w0", 32'(init_done), 32'd0);
        wait_req(n);
        check_val("cfg_gap", 32'(n), 32'd1);
        ack_txn(8, 16'h0, 0);
        check_val("init_done_set", 32'(init_done), 32'd1);
        check_val("cfg_index_wrap", 32'(cfg_index), 32'd0);
        push_txn(1'b0, 5'd1, 16'h0);
        wait_req(n);
        check_val("poll_issue_gap", 32'(n), 32'd1);

        ack_txn(8, 16'h796D, 0);
        check_val("poll1_link_up", 32'(link_up), 32'd1);
        check_val("poll1_change", 32'(link_change), 32'd1);
        push_txn(1'b0, 5'd1, 16'h0);
        tick();
        check_val("poll1_change_end", 32'(link_change), 32'd0);
        wait_req(n);
        check_val("poll_gap", 32'(n + 1), 32'd20);

        ack_txn(8, 16'h7969, 0);
        check_val("poll2_link_up", 32'(link_up), 32'd0);
        check_val("poll2_change", 32'(link_change), 32'd1);
        push_txn(1'b0, 5'd1, 16'h0);
        tick();
        check_val("poll2_change_end", 32'(link_change), 32'd0);
        wait_req(n);

        ack_txn(8, 16'h7969, 0);
        check_val("poll3_link_up", 32'(link_up), 32'd0);
        check_val("poll3_no_change", 32'(link_change), 32'd0);
        push_txn(1'b0, 5'd1, 16'h0);
        tick();
        wait_req(n);

        ack_txn(8, 16'h796D, 0);
        check_val("poll4_link_up", 32'(link_up), 32'd1);
        check_val("poll4_change", 32'(link_change), 32'd1);

        // Restart from POLL_IDLE; a stray ack during reset hold is ignored.
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_val("rs_eth_reset_n", 32'(eth_reset_n), 32'd0);
        check_val("rs_link_up", 32'(link_up), 32'd0);
        check_val("rs_link_change", 32'(link_change), 32'd1);
        check_val("rs_init_done", 32'(init_done), 32'd0);
        bus.mdio_ack = 1'b1;
        tick();
        bus.mdio_ack = 1'b0;
        wait_rst_rise(1, n);
        check_val("rs_low_cycles", 32'(n), 32'd10);

        // Run 2: restart while write 0 is outstanding.
        push_txn(1'b1, 5'd0, 16'h1140);
        wait_req(n);
        check_val("run2_req_gap", 32'(n), 32'd6);
        ack_txn(8, 16'h0, 1);
        check_val("run2_eth_reset_n", 32'(eth_reset_n), 32'd0);
        check_val("run2_cfg_index", 32'(cfg_index), 32'd0);
        check_val("run2_init_done", 32'(init_done), 32'd0);
        wait_rst_rise(0, n);
        check_val("run2_low_cycles", 32'(n), 32'd10);

        // Run 3: restart coincident with the ack.
        push_txn(1'b1, 5'd0, 16'h1140);
        wait_req(n);
        ack_txn(8, 16'h0, 2);
        check_val("run3_eth_reset_n", 32'(eth_reset_n), 32'd0);
        check_val("run3_cfg_index", 32'(cfg_index), 32'd0);
        wait_rst_rise(0, n);
        check_val("run3_low_cycles", 32'(n), 32'd10);

        // Run 4: sequence repeats from write 0.
        push_txn(1'b1, 5'd0, 16'h1140);
        push_txn(1'b1, 5'd4, 16'h01E1);
        wait_req(n);
        check_val("run4_req_gap", 32'(n), 32'd6);
        ack_txn(8, 16'h0, 0);
        check_val("run4_cfg_index", 32'(cfg_index), 32'd1);
        wait_req(n);
        ack_txn(8, 16'h0, 0);
        check_val("run4_init_done", 32'(init_done), 32'd1);
        push_txn(1'b0, 5'd1, 16'h0);
        wait_req(n);

`ifdef ETH_PHY_TIMEOUT_EN
        n = 0;
        while (bus.mdio_req && n < 200) begin tick(); n++; end
        check_val("tmo_req_len", 32'(n), 32'd50);
        check_val("tmo_error", 32'(error), 32'd1);
        check_val("tmo_eth_reset_n", 32'(eth_reset_n), 32'd0);
        check_val("tmo_init_done", 32'(init_done), 32'd0);
        bus.mdio_ack = 1'b1;
        bus.mdio_rdata = 16'h796D;
        tick();
        bus.mdio_ack = 1'b0;
        check_val("tmo_late_ack_link", 32'(link_up), 32'd0);
        wait_rst_rise(1, n);
        check_val("tmo_low_cycles", 32'(n), 32'd10);
        check_val("tmo_error_sticky", 32'(error), 32'd1);
`else
        repeat (60) tick();
        check_val("notmo_req_held", 32'(bus.mdio_req), 32'd1);
        check_val("notmo_error", 32'(error), 32'd0);
        ack_txn(1, 16'h796D, 0);
        check_val("notmo_link_up", 32'(link_up), 32'd1);
        check_val("notmo_change", 32'(link_change), 32'd1);
`endif

        n = 0;
        while (!done0 && n < 1000) begin tick(); n++; end
        check_val("nc0_done", 32'(done0), 32'd1);
        check_val("sb_empty", 32'(q_exp.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
